// File: rtl/md_sched_unit_pkg.sv
// Shared definitions for the multiply/divide scheduler: op encodings,
// default latencies and FSM states.
package md_sched_unit_pkg;

  typedef enum logic [2:0] {
    MD_MULT  = 3'd0,
    MD_MULTU = 3'd1,
    MD_DIV   = 3'd2,
    MD_DIVU  = 3'd3,
    MD_MTHI  = 3'd4,
    MD_MTLO  = 3'd5
  } md_op_e;

  typedef enum logic {
    ST_IDLE = 1'b0,
    ST_RUN  = 1'b1
  } md_state_e;

  localparam int MD_MULT_CYC_DEF = 5;
  localparam int MD_DIV_CYC_DEF  = 10;

  // Ops that occupy the unit for a multi-cycle computation.
  function automatic logic md_is_calc(input logic [2:0] op);
    return op <= 3'd3;
  endfunction

  // Ops that do anything at all (6/7 are no-ops).
  function automatic logic md_is_valid(input logic [2:0] op);
    return op <= 3'd5;
  endfunction

endpackage

// File: rtl/md_sched_unit_arith.sv
// Combinational HI/LO result generator for mult/multu/div/divu.
// Division works on magnitudes so INT_MIN / -1 wraps cleanly to INT_MIN
// with zero remainder, and a zero divisor is replaced by 1 so the divider
// never sees an undefined case (the result is discarded anyway).
module md_sched_unit_arith
  import md_sched_unit_pkg::*;
(
  input  logic [2:0]  op,
  input  logic [31:0] a,
  input  logic [31:0] b,
  output logic [31:0] hi,
  output logic [31:0] lo,
  output logic        div_zero
);

  logic        sgn, is_div, a_neg, b_neg;
  logic [63:0] prod;
  logic [31:0] a_mag, b_mag, dvs, q_mag, r_mag, quo, rem;

  // Product and quotient/remainder selection
  always_comb begin
    sgn    = (op == MD_MULT) || (op == MD_DIV);
    is_div = (op == MD_DIV)  || (op == MD_DIVU);
    a_neg  = sgn & a[31];
    b_neg  = sgn & b[31];

    if (sgn) prod = {{32{a[31]}}, a} * {{32{b[31]}}, b};
    else     prod = {32'd0, a} * {32'd0, b};

    a_mag = a_neg ? (32'd0 - a) : a;
    b_mag = b_neg ? (32'd0 - b) : b;
    dvs   = (b == 32'd0) ? 32'd1 : b_mag;
    q_mag = a_mag / dvs;
    r_mag = a_mag % dvs;
    // Truncate toward zero; remainder follows the dividend's sign.
    quo   = (a_neg ^ b_neg) ? (32'd0 - q_mag) : q_mag;
    rem   = a_neg ? (32'd0 - r_mag) : r_mag;

    hi       = is_div ? rem : prod[63:32];
    lo       = is_div ? quo : prod[31:0];
    div_zero = is_div && (b == 32'd0);
  end

endmodule

// File: rtl/md_sched_unit.sv
// Multi-cycle mult/div unit with HI/LO ownership, fixed-latency busy
// counter and the D-stage stall request. Result is computed at issue and
// held in a pending pair until the counter expires.
module md_sched_unit
  import md_sched_unit_pkg::*;
#(
  parameter int MULT_CYC = MD_MULT_CYC_DEF,
  parameter int DIV_CYC  = MD_DIV_CYC_DEF
) (
  input  logic        Clk,
  input  logic        Rst,
  input  logic        Start,
  input  logic [2:0]  MDOp,
  input  logic [31:0] A,
  input  logic [31:0] B,
  input  logic        Flush,
  input  logic        D_MDUse,
  output logic        Busy,
  output logic        Stall,
  output logic [31:0] HI,
  output logic [31:0] LO
);

  localparam int MAX_CYC = (MULT_CYC > DIV_CYC) ? MULT_CYC : DIV_CYC;
  localparam int CNT_W   = $clog2(MAX_CYC + 1);

  md_state_e        state_q, state_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic [31:0]      hi_q, hi_d, lo_q, lo_d;
  logic [31:0]      pend_hi_q, pend_hi_d, pend_lo_q, pend_lo_d;
  logic             pend_dz_q, pend_dz_d;

  logic [31:0]      res_hi, res_lo;
  logic             res_dz;
  logic             accept, issue_calc;

  md_sched_unit_arith u_arith (
    .op       (MDOp),
    .a        (A),
    .b        (B),
    .hi       (res_hi),
    .lo       (res_lo),
    .div_zero (res_dz)
  );

  assign accept     = Start & ~Flush & (state_q == ST_IDLE) & md_is_valid(MDOp);
  assign issue_calc = Start & ~Flush & md_is_calc(MDOp);

  // Next-state: issue, counting and HI/LO commit
  always_comb begin
    state_d   = state_q;
    cnt_d     = cnt_q;
    hi_d      = hi_q;
    lo_d      = lo_q;
    pend_hi_d = pend_hi_q;
    pend_lo_d = pend_lo_q;
    pend_dz_d = pend_dz_q;
    case (state_q)
      ST_IDLE: begin
        if (accept) begin
          if (md_is_calc(MDOp)) begin
            pend_hi_d = res_hi;
            pend_lo_d = res_lo;
            pend_dz_d = res_dz;
            cnt_d     = ((MDOp == MD_DIV) || (MDOp == MD_DIVU)) ?
                        CNT_W'(DIV_CYC) : CNT_W'(MULT_CYC);
            state_d   = ST_RUN;
          end else if (MDOp == MD_MTHI) begin
            hi_d = A;
          end else begin
            lo_d = A;
          end
        end
      end
      ST_RUN: begin
        // Flush is deliberately ignored here: the op in flight is older
        // than the excepting instruction and must complete.
        if (cnt_q <= CNT_W'(1)) begin
          cnt_d   = '0;
          state_d = ST_IDLE;
          if (!pend_dz_q) begin
            hi_d = pend_hi_q;
            lo_d = pend_lo_q;
          end
        end else begin
          cnt_d = cnt_q - CNT_W'(1);
        end
      end
      default: state_d = ST_IDLE;
    endcase
  end

  // State registers; reset drops any pending result
  always_ff @(posedge Clk or posedge Rst) begin
    if (Rst) begin
      state_q   <= ST_IDLE;
      cnt_q     <= '0;
      hi_q      <= '0;
      lo_q      <= '0;
      pend_hi_q <= '0;
      pend_lo_q <= '0;
      pend_dz_q <= 1'b0;
    end else begin
      state_q   <= state_d;
      cnt_q     <= cnt_d;
      hi_q      <= hi_d;
      lo_q      <= lo_d;
      pend_hi_q <= pend_hi_d;
      pend_lo_q <= pend_lo_d;
      pend_dz_q <= pend_dz_d;
    end
  end

  assign Busy  = (state_q == ST_RUN);
  assign Stall = D_MDUse & (Busy | issue_calc);
  assign HI    = hi_q;
  assign LO    = lo_q;

endmodule

// File: doc/md_sched_unit.md
Name: md_sched_unit

Overview:
- Multi-cycle multiply/divide unit with its own issue scheduler for the 5-stage MIPS pipeline.
- Owns the HI/LO registers and executes mult/multu/div/divu/mthi/mtlo issued from the E stage.
- Models the fixed mult/div latency with a busy counter.
- Produces the stall request that freezes D when a dependent MD instruction arrives, and honours the exception flush from CP0.

Parameters:
- MULT_CYC, 5, cycles from start to HI/LO commit for mult/multu
- DIV_CYC, 10, cycles from start to HI/LO commit for div/divu

Ports:
- Clk  input  1  system clock, rising edge
- Rst  input  1  asynchronous, active-high reset
- Start  input  1  E-stage instruction is an MD op this cycle
- MDOp  input  3  0 mult, 1 multu, 2 div, 3 divu, 4 mthi, 5 mtlo, others no-op
- A  input  32  rs operand (forwarded)
- B  input  32  rt operand (forwarded)
- Flush  input  1  exception/interrupt taken this cycle; the E-stage op must not take effect
- D_MDUse  input  1  D-stage instruction is an MD op or mfhi/mflo
- Busy  output  1  computation in progress
- Stall  output  1  freeze F/D, bubble into E
- HI  output  32  current HI register
- LO  output  32  current LO register

Behaviour:
- Reset (async, Rst=1): state IDLE, counter 0, HI=0, LO=0, Busy=0, Stall=0. Applies immediately, even mid-computation; a pending result is discarded.
- States: IDLE, RUN.
- Accept condition: Start=1, MDOp valid, Flush=0, state IDLE.
- IDLE, accepted mult/multu/div/divu:
  - Latch operands, compute the result into an internal pending pair.
  - Load counter with MULT_CYC or DIV_CYC; go to RUN; Busy=1 from the next edge.
- IDLE, accepted mthi/mtlo: HI (or LO) <= A at this edge; no RUN state; Busy stays 0.
- RUN:
  - Counter decrements each edge.
  - On the edge where counter reaches 1, commit pending values to HI/LO, clear Busy, return to IDLE.
  - Busy is high for exactly MULT_CYC/DIV_CYC cycles.
  - HI/LO keep their old values until the commit edge.
- Start while RUN: ignored. Stall guarantees this cannot occur legally; the bench flags it as an error.
- Flush=1 with Start: op suppressed (no state change, no HI/LO write).
- Flush while RUN: the already-issued computation continues and commits (the older instruction has completed architecturally).
- Stall = D_MDUse & (Busy | (Start & MDOp in {0..3} & ~Flush)). Combinational; high on the issue cycle and throughout RUN.
- Arithmetic:
  - mult: signed 32x32 -> {HI,LO} 64-bit product.
  - multu: unsigned 32x32 -> {HI,LO} 64-bit product.
  - div/divu: LO = quotient, HI = remainder.
  - Signed division truncates toward zero; remainder takes the sign of the dividend.
  - Divide by zero: RUN still lasts DIV_CYC cycles, then HI/LO are left unchanged.
  - Signed 0x80000000 / -1: LO = 0x80000000, HI = 0.
- MDOp 6/7 with Start=1: no effect.

Decomposition:
- Shared package holds:
  - MDOp encodings (MD_MULT, MD_MULTU, MD_DIV, MD_DIVU, MD_MTHI, MD_MTLO).
  - MULT_CYC/DIV_CYC defaults.
  - State encodings.
- Optional sub-module md_arith: combinational 64-bit result generator (mult/div/signedness, div-by-zero flag).
- The scheduler FSM, counter, HI/LO and stall logic stay in md_sched_unit.

Test Plan:
- mult A=0xFFFFFFFE (-2), B=3 -> Busy high for 5 cycles; HI=0xFFFFFFFF, LO=0xFFFFFFFA at the commit edge; HI/LO unchanged before it.
- divu A=7, B=2, D_MDUse=1 throughout -> Stall high for 11 cycles (issue cycle + 10 busy); HI=1, LO=3 after the 10th edge.
- div A=0xFFFFFFF9 (-7), B=2 -> LO=0xFFFFFFFD, HI=0xFFFFFFFF. Then div A=5, B=0 -> after 10 cycles HI/LO still 0xFFFFFFFF/0xFFFFFFFD.
- mthi A=0x12345678 with Flush=1 -> HI unchanged. Repeat with Flush=0 -> HI=0x12345678 next edge, Busy=0.
- Start mult, assert Flush on cycle 2 of RUN -> result still commits after 5 cycles.
- Start div, assert Rst mid-RUN (cycle 4) -> Busy=0, HI=LO=0 immediately; no later commit.
